// File: rtl/alu_pkg.sv
// Shared types and latency rules for the ALU result-capture stage.
// Optional tag support is enabled with the ALU_RC_TAG_EN macro.
package alu_pkg;

    localparam int ALU_DW = 8;
    localparam int ALU_CW = 4;
    localparam int ALU_TW = 4;

    localparam int LAT_SHORT = 2;
    localparam int LAT_LONG  = 4;

    localparam logic [3:0] CMD_INC_MUL = 4'd9;
    localparam logic [3:0] CMD_SHL_SUB = 4'd10;

    // One captured ALU result; flags are {err, l, e, g, oflow, cout}.
    typedef struct packed {
        logic [ALU_DW+1:0] res;
        logic              res_nv;
        logic [5:0]        flags;
`ifdef ALU_RC_TAG_EN
        logic [ALU_TW-1:0] tag;
`endif
    } alu_res_t;

    function automatic int alu_lat(input logic mode, input logic [ALU_CW-1:0] cmd);
        if (mode && (cmd == CMD_INC_MUL || cmd == CMD_SHL_SUB))
            return LAT_LONG;
        return LAT_SHORT;
    endfunction

endpackage

// File: rtl/alu_rc_fifo.sv
// First-word-fall-through FIFO for captured ALU results, with an occupancy count.
module alu_rc_fifo #(
    parameter int  DEPTH = 4,
    parameter type T     = logic [7:0]
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push_i,
    input  T                       data_i,
    input  logic                   pop_i,
    output logic                   vld_o,
    output T                       data_o,
    output logic                   full_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int AW = $clog2(DEPTH);

    T               mem_q [DEPTH];
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW:0]    count_q, count_d;
    logic           do_push, do_pop;

    assign vld_o   = (count_q != '0);
    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign count_o = count_q;
    assign data_o  = vld_o ? mem_q[rd_ptr_q] : '0;

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && vld_o;

    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is not reset; empty-gating of data_o hides stale contents.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/alu_result_capture.sv
// Tracks issued ALU ops through their latency, samples and normalises results, and queues them.
// Define ALU_RC_TAG_EN to carry a per-op tag through to the output.
module alu_result_capture
    import alu_pkg::*;
#(
    parameter int DW    = ALU_DW,
    parameter int CW    = ALU_CW,
    parameter int DEPTH = 4,
    parameter int TW    = ALU_TW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          issue_i,
    input  logic          issue_mode_i,
    input  logic [CW-1:0] issue_cmd_i,
`ifdef ALU_RC_TAG_EN
    input  logic [TW-1:0] issue_tag_i,
`endif
    output logic          issue_rdy_o,
    input  logic [DW+1:0] res_i,
    input  logic          cout_i,
    input  logic          oflow_i,
    input  logic          g_i,
    input  logic          e_i,
    input  logic          l_i,
    input  logic          err_i,
    output logic          out_vld_o,
    input  logic          out_rdy_i,
    output logic [DW+1:0] out_res_o,
    output logic          out_res_nv_o,
    output logic [5:0]    out_flags_o,
`ifdef ALU_RC_TAG_EN
    output logic [TW-1:0] out_tag_o,
`endif
    output logic [2:0]    inflight_o
);

    localparam int NSLOT = LAT_LONG;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [NSLOT:1]  slot_q, slot_d;
    logic [2:0]      inflight_q, inflight_d;
    logic            is_long, slot_free, credit_ok;
    logic            accept, capture;
    int              tgt;
    alu_res_t        cap_entry, head;
    logic [CNT_W-1:0] fifo_count;
    logic            fifo_full, fifo_vld;

    // Slot LAT is marked at accept; a long op never collides because slot 5 does not exist.
    always_comb begin
        is_long     = (alu_lat(issue_mode_i, issue_cmd_i) == LAT_LONG);
        tgt         = is_long ? LAT_LONG : LAT_SHORT;
        slot_free   = is_long || !slot_q[LAT_SHORT+1];
        credit_ok   = (int'(fifo_count) + int'(inflight_q)) < DEPTH;
        issue_rdy_o = rst_n && slot_free && credit_ok;
    end

    assign accept  = issue_i && issue_rdy_o;
    assign capture = slot_q[1];

    always_comb begin
        slot_d = {1'b0, slot_q[NSLOT:2]};
        if (accept) slot_d[tgt] = 1'b1;
        unique case ({accept, capture})
            2'b10:   inflight_d = inflight_q + 3'd1;
            2'b01:   inflight_d = inflight_q - 3'd1;
            default: inflight_d = inflight_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q     <= '0;
            inflight_q <= '0;
        end else begin
            slot_q     <= slot_d;
            inflight_q <= inflight_d;
        end
    end

`ifdef ALU_RC_TAG_EN
    logic [TW-1:0] tag_q [NSLOT:1];
    logic [TW-1:0] tag_d [NSLOT:1];

    always_comb begin
        for (int i = 1; i < NSLOT; i++) tag_d[i] = tag_q[i+1];
        tag_d[NSLOT] = '0;
        if (accept) tag_d[tgt] = issue_tag_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i <= NSLOT; i++) tag_q[i] <= '0;
        end else begin
            for (int i = 1; i <= NSLOT; i++) tag_q[i] <= tag_d[i];
        end
    end
`endif

    // Undriven (z) or unknown result bits read as 0 and raise res_nv.
    always_comb begin
        cap_entry = '0;
        for (int i = 0; i < DW + 2; i++) begin
            cap_entry.res[i] = (res_i[i] === 1'b1);
            if ((res_i[i] !== 1'b0) && (res_i[i] !== 1'b1)) cap_entry.res_nv = 1'b1;
        end
        cap_entry.flags = {err_i === 1'b1, l_i === 1'b1, e_i === 1'b1,
                           g_i === 1'b1, oflow_i === 1'b1, cout_i === 1'b1};
`ifdef ALU_RC_TAG_EN
        cap_entry.tag = tag_q[1];
`endif
    end

    alu_rc_fifo #(
        .DEPTH (DEPTH),
        .T     (alu_res_t)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (capture),
        .data_i  (cap_entry),
        .pop_i   (out_rdy_i),
        .vld_o   (fifo_vld),
        .data_o  (head),
        .full_o  (fifo_full),
        .count_o (fifo_count)
    );

    assign out_vld_o    = fifo_vld;
    assign out_res_o    = head.res;
    assign out_res_nv_o = head.res_nv;
    assign out_flags_o  = head.flags;
`ifdef ALU_RC_TAG_EN
    assign out_tag_o    = head.tag;
`endif
    assign inflight_o   = inflight_q;

    // Issue credit makes a capture into a full FIFO unreachable.
    no_push_on_full : assert property (@(posedge clk) disable iff (!rst_n) !(capture && fifo_full));

endmodule
